scarv_uart_tx_arb: RTL and testbench
====================================

# scarv_uart_tx_arb

Round-robin arbiter that shares the SoC's single UART transmit channel between NREQ byte-stream requesters (e.g. CPU UART peripheral, debug/trace unit, self-test monitor). A grant is locked for a whole message, delimited by a `last` flag, so bytes from different sources never interleave on `uart_txd`. It sits between the requesters and the UART TX serialiser inside the system top, in the `g_clk` domain.

## Interface
- `NREQ`, default 2: number of requesters, range 2..8.
- `TIMEOUT`, default 255: idle cycles after which a locked grant is forcibly released. Only used with `SCARV_UART_ARB_TIMEOUT_EN`.
- `g_clk` in 1: system clock. One clock only.
- `g_resetn` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: requester i has a byte.
- `req_data` in 8*NREQ: byte of requester i is at bits [8i+7:8i].
- `req_last` in NREQ: byte is the last of its message.
- `req_ready` out NREQ: byte of requester i accepted this cycle.
- `tx_valid` out 1: byte to UART TX serialiser.
- `tx_data` out 8: byte to serialiser.
- `tx_ready` in 1: serialiser accepts byte.
- `grant` out NREQ: one-hot current owner; all-zero when idle.
- `busy` out 1: `|grant`.
- `timeout_evt` out 1: 1-cycle pulse on forced release.

## Operation
- States: IDLE (`grant`=0) and LOCKED (`grant` one-hot, registered).
- IDLE: if any `req_valid`, select the first valid index at or after `rr_ptr`, wrapping modulo NREQ. Load `grant` and go to LOCKED. No bytes pass in IDLE.
- LOCKED, owner k:
  - `tx_valid` = `req_valid[k]`; `tx_data` = `req_data[k]`.
  - `req_ready[k]` = `tx_ready`; all other `req_ready` bits are 0.
  - These paths are combinational from the inputs and `grant`.
- Release: a handshake (`tx_valid & tx_ready`) with `req_last[k]`=1. Next state is IDLE and `rr_ptr` becomes (k+1) mod NREQ.
- Requesters must hold `valid`, `data` and `last` stable until `ready`. The arbiter never changes owner while `tx_valid` is high and unaccepted.
- Non-owner requests wait, with no limit other than the owner's message length (or the timeout).
- Single-byte messages (`last`=1 on the first byte) are legal.
- `rr_ptr` is a registered value of width clog2(NREQ).

## Timing
- Reset values: `grant`=0, `busy`=0, `tx_valid`=0, `req_ready`=0, `timeout_evt`=0, `rr_ptr`=0, idle counter=0. Outputs clear immediately on `g_resetn` low, including in the middle of a message. The partial message is dropped and the requester restarts it.
- Arbitration latency: `req_valid` seen in cycle N gives `grant` and `tx_valid` in cycle N+1. If `tx_ready`=1, the first byte is accepted in N+1.
- Throughput while LOCKED: one byte per cycle when `tx_ready` is held high.
- Release gap: a last-byte handshake in cycle M gives IDLE in M+1 and the next grant in M+2. Re-arbitration in M+1 already uses the updated `rr_ptr`.
- Simultaneous requests in IDLE: the lowest index at or after `rr_ptr` wins.
- The former owner re-requesting immediately is lowest priority for that arbitration round.

## Configuration
- `SCARV_UART_ARB_TIMEOUT_EN` defined:
  - In LOCKED, an 8-bit+ counter increments each cycle that `req_valid[k]`=0. It clears on any owner valid.
  - When the counter reaches TIMEOUT, the lock is released exactly as for `last` (IDLE next cycle, `rr_ptr`=k+1) and `timeout_evt` pulses for 1 cycle.
  - The counter never runs while `tx_valid`=1, so handshake stability is preserved.
- Macro undefined: no counter is built, `timeout_evt` is tied to 0, and the lock is held until `last`. `TIMEOUT` is ignored.

## Test plan
- Reset: `g_resetn`=0 with `req_valid`=2'b11 -> `grant`=0, `tx_valid`=0, `req_ready`=0. After release, requester 0 is granted 1 cycle later.
- Both requesters send 3-byte messages (r0: 0x41,0x42,0x43 last; r1: 0x61,0x62,0x63 last), `tx_ready`=1 -> `tx_data` sequence is 41,42,43,61,62,63 with no interleave. `grant` is 01 then 10, with 1 idle cycle between the messages.
- Fairness: r0 streams 1-byte messages continuously and r1 requests -> grants alternate 01,10,01. r1 is never starved.
- Backpressure: `tx_ready`=0 for 5 cycles mid-message -> `tx_valid` and `tx_data` are held, `req_ready`=0, `grant` is unchanged. The byte is accepted on the first cycle `tx_ready`=1.
- Timeout (macro on, TIMEOUT=4): owner r0 sends 0x10 without `last`, then drops valid -> after 4 idle cycles `timeout_evt`=1 and a pending r1 is granted the next cycle. With the macro off, r1 stays blocked indefinitely.
- Reset mid-message: assert `g_resetn`=0 after byte 2 of 4 -> all outputs go to 0 asynchronously and `rr_ptr`=0 after release.

Source files
------------

// File: rtl/scarv_uart_tx_arb_if.sv
// scarv_uart_tx_arb_if: requester/serialiser handshake bundle for scarv_uart_tx_arb
interface scarv_uart_tx_arb_if #(parameter int NREQ = 2);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout_evt;
  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, grant, busy, timeout_evt
  );
  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, grant, busy, timeout_evt
  );
endinterface

// File: rtl/scarv_uart_tx_arb.sv
// scarv_uart_tx_arb: message-locked round-robin arbiter for the shared UART TX channel
// Optional idle-owner forced release is built when SCARV_UART_ARB_TIMEOUT_EN is defined
module scarv_uart_tx_arb #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input logic                g_clk,
  input logic                g_resetn,
  scarv_uart_tx_arb_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, pick;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d, owner, owner_nxt, j;
  logic [7:0]      data_sel;
  logic            found, last_sel, hs, tmo, rel;
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("scarv_uart_tx_arb: NREQ must be 2..8 and TIMEOUT >= 1");
  end
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = PW'((int'(rr_ptr_q) + i) % NREQ);
      if (!found && bus.req_valid[j]) begin
        pick[j] = 1'b1;
        found   = 1'b1;
      end
    end
  end
  always_comb begin
    owner    = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner    = PW'(i);
        data_sel = bus.req_data[8*i +: 8];
      end
    end
  end
  assign owner_nxt     = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
  assign bus.tx_valid  = |(grant_q & bus.req_valid);
  assign bus.tx_data   = data_sel;
  assign bus.req_ready = grant_q & {NREQ{bus.tx_ready}};
  assign bus.grant     = grant_q;
  assign bus.busy      = |grant_q;
  assign last_sel      = |(grant_q & bus.req_last);
  assign hs            = bus.tx_valid & bus.tx_ready;
  assign rel           = (hs & last_sel) | tmo;
`ifdef SCARV_UART_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          evt_q;
  // only counts while the owner offers nothing, so a pending byte is never abandoned
  assign tmo   = (state_q == LOCKED) && !bus.tx_valid && (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d = (state_q == IDLE || bus.tx_valid || tmo) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      cnt_q <= '0;
      evt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= tmo;
    end
  end
  assign bus.timeout_evt = evt_q;
`else
  assign tmo             = 1'b0;
  assign bus.timeout_evt = 1'b0;
`endif
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE) begin
      if (|bus.req_valid) begin
        state_d = LOCKED;
        grant_d = pick;
      end
    end else if (rel) begin
      state_d  = IDLE;
      grant_d  = '0;
      rr_ptr_d = owner_nxt;
    end
  end
endmodule

// File: tb/tb_scarv_uart_tx_arb.sv
// tb_scarv_uart_tx_arb: cycle vector table plus byte-order scoreboard for scarv_uart_tx_arb
`timescale 1ns/1ps
module tb_scarv_uart_tx_arb;
  logic clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 clk = ~clk;
  scarv_uart_tx_arb_if #(.NREQ(2)) bus();
  scarv_uart_tx_arb #(.NREQ(2), .TIMEOUT(4)) dut (.g_clk(clk), .g_resetn(g_resetn), .bus(bus));

  typedef struct {
    logic rstn; logic [1:0] rv; logic [15:0] rd; logic [1:0] rl; logic txr;
    logic [1:0] g; logic v; logic [7:0] d; logic [1:0] rdy;
  } vec_t;
  vec_t       vt[$];
  logic [7:0] sb[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic rstn, input logic [1:0] rv, input logic [15:0] rd,
                              input logic [1:0] rl, input logic txr, input logic [1:0] g,
                              input logic v, input logic [7:0] d, input logic [1:0] rdy);
    vec_t t;
    t.rstn = rstn; t.rv = rv; t.rd = rd; t.rl = rl; t.txr = txr;
    t.g = g; t.v = v; t.d = d; t.rdy = rdy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rstn, input logic [1:0] rv, input logic [15:0] rd,
                       input logic [1:0] rl, input logic txr);
    @(posedge clk);
    #1;
    g_resetn      = rstn;
    bus.req_valid = rv;
    bus.req_data  = rd;
    bus.req_last  = rl;
    bus.tx_ready  = txr;
    #3;
  endtask

  // every accepted byte must be the next one the bench expects
  always @(negedge clk) begin
    if (g_resetn && bus.tx_valid && bus.tx_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_extra: got byte %h want none at %0t", bus.tx_data, $time);
      end else begin
        chk("sb_byte", 16'(bus.tx_data), 16'(sb.pop_front()));
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;
    // reset, then two 3-byte messages
    vt.push_back(mk(0, 2'b11, 16'h6141, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b11, 16'h6141, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b11, 16'h6141, 2'b00, 1, 2'b01, 1, 8'h41, 2'b01));
    vt.push_back(mk(1, 2'b11, 16'h6142, 2'b00, 1, 2'b01, 1, 8'h42, 2'b01));
    vt.push_back(mk(1, 2'b11, 16'h6143, 2'b01, 1, 2'b01, 1, 8'h43, 2'b01));
    vt.push_back(mk(1, 2'b10, 16'h6100, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b10, 16'h6100, 2'b00, 1, 2'b10, 1, 8'h61, 2'b10));
    vt.push_back(mk(1, 2'b10, 16'h6200, 2'b00, 1, 2'b10, 1, 8'h62, 2'b10));
    vt.push_back(mk(1, 2'b10, 16'h6300, 2'b10, 1, 2'b10, 1, 8'h63, 2'b10));
    vt.push_back(mk(1, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
    // fairness: r0 streams single-byte messages, r1 still gets its turn
    vt.push_back(mk(1, 2'b11, 16'h7150, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b11, 16'h7150, 2'b11, 1, 2'b01, 1, 8'h50, 2'b01));
    vt.push_back(mk(1, 2'b11, 16'h7151, 2'b11, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b11, 16'h7151, 2'b11, 1, 2'b10, 1, 8'h71, 2'b10));
    vt.push_back(mk(1, 2'b01, 16'h0051, 2'b01, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b01, 16'h0051, 2'b01, 1, 2'b01, 1, 8'h51, 2'b01));
    vt.push_back(mk(1, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
    // backpressure: 5 stalled cycles mid-message with r1 waiting
    vt.push_back(mk(1, 2'b01, 16'h00a0, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b01, 16'h00a0, 2'b00, 1, 2'b01, 1, 8'ha0, 2'b01));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(1, 2'b11, 16'h81a1, 2'b10, 0, 2'b01, 1, 8'ha1, 2'b00));
    vt.push_back(mk(1, 2'b11, 16'h81a1, 2'b11, 1, 2'b01, 1, 8'ha1, 2'b01));
    vt.push_back(mk(1, 2'b10, 16'h8100, 2'b10, 1, 2'b00, 0, 8'h00, 2'b00));
    vt.push_back(mk(1, 2'b10, 16'h8100, 2'b10, 1, 2'b10, 1, 8'h81, 2'b10));
    vt.push_back(mk(1, 2'b00, 16'h0000, 2'b00, 1, 2'b00, 0, 8'h00, 2'b00));
    sb = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h63, 8'h50, 8'h71, 8'h51, 8'ha0, 8'ha1, 8'h81};

    foreach (vt[i]) begin
      drive(vt[i].rstn, vt[i].rv, vt[i].rd, vt[i].rl, vt[i].txr);
      chk($sformatf("v%0d_grant", i), 16'(bus.grant), 16'(vt[i].g));
      chk($sformatf("v%0d_busy", i), 16'(bus.busy), 16'(|vt[i].g));
      chk($sformatf("v%0d_tx_valid", i), 16'(bus.tx_valid), 16'(vt[i].v));
      chk($sformatf("v%0d_req_ready", i), 16'(bus.req_ready), 16'(vt[i].rdy));
      chk($sformatf("v%0d_timeout_evt", i), 16'(bus.timeout_evt), 16'h0);
      if (vt[i].v) chk($sformatf("v%0d_tx_data", i), 16'(bus.tx_data), 16'(vt[i].d));
    end

    // reset mid-message: leave rr_ptr at 1, then reset during r1's 4-byte message
    sb.push_back(8'h33);
    drive(1, 2'b01, 16'h0033, 2'b01, 1);
    drive(1, 2'b01, 16'h0033, 2'b01, 1);
    chk("mr_r0_grant", 16'(bus.grant), 16'h1);
    sb.push_back(8'h91);
    sb.push_back(8'h92);
    drive(1, 2'b10, 16'h9100, 2'b00, 1);
    drive(1, 2'b10, 16'h9100, 2'b00, 1);
    chk("mr_b1_data", 16'(bus.tx_data), 16'h91);
    drive(1, 2'b10, 16'h9200, 2'b00, 1);
    drive(1, 2'b11, 16'h9355, 2'b01, 0);
    chk("mr_pre_grant", 16'(bus.grant), 16'h2);
    chk("mr_pre_valid", 16'(bus.tx_valid), 16'h1);
    bus.tx_ready = 1'b1;
    g_resetn     = 1'b0;
    #0.5;
    chk("mr_async_grant", 16'(bus.grant), 16'h0);
    chk("mr_async_valid", 16'(bus.tx_valid), 16'h0);
    chk("mr_async_ready", 16'(bus.req_ready), 16'h0);
    chk("mr_async_busy", 16'(bus.busy), 16'h0);
    drive(0, 2'b11, 16'h9355, 2'b01, 1);
    chk("mr_rst_grant", 16'(bus.grant), 16'h0);
    drive(1, 2'b11, 16'h9355, 2'b01, 1);
    chk("mr_idle_grant", 16'(bus.grant), 16'h0);
    sb.push_back(8'h55);
    drive(1, 2'b11, 16'h9355, 2'b01, 1);
    chk("mr_rrptr_grant", 16'(bus.grant), 16'h1);
    chk("mr_rrptr_data", 16'(bus.tx_data), 16'h55);

    // owner r0 goes quiet after an unterminated byte while r1 waits
    drive(1, 2'b01, 16'h0010, 2'b00, 1);
    sb.push_back(8'h10);
    drive(1, 2'b11, 16'h2010, 2'b10, 1);
    chk("to_owner", 16'(bus.grant), 16'h1);
`ifdef SCARV_UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b10, 16'h2000, 2'b10, 1);
      chk($sformatf("to_wait%0d_grant", i), 16'(bus.grant), 16'h1);
      chk($sformatf("to_wait%0d_evt", i), 16'(bus.timeout_evt), 16'h0);
      chk($sformatf("to_wait%0d_ready", i), 16'(bus.req_ready), 16'h1);
    end
    drive(1, 2'b10, 16'h2000, 2'b10, 1);
    chk("to_evt", 16'(bus.timeout_evt), 16'h1);
    chk("to_evt_grant", 16'(bus.grant), 16'h0);
    sb.push_back(8'h20);
    drive(1, 2'b10, 16'h2000, 2'b10, 1);
    chk("to_r1_grant", 16'(bus.grant), 16'h2);
    chk("to_r1_data", 16'(bus.tx_data), 16'h20);
    chk("to_evt_pulse", 16'(bus.timeout_evt), 16'h0);
`else
    for (int i = 0; i < 20; i++) begin
      drive(1, 2'b10, 16'h2000, 2'b10, 1);
      chk($sformatf("blk%0d_grant", i), 16'(bus.grant), 16'h1);
      chk($sformatf("blk%0d_evt", i), 16'(bus.timeout_evt), 16'h0);
    end
`endif
    drive(1, 2'b00, 16'h0000, 2'b00, 1);
    drive(1, 2'b00, 16'h0000, 2'b00, 1);
    chk("sb_empty", 16'(sb.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
